// File: rtl/pipe_add_sub_if.sv
// -----------------------------------------------------------------------------
// pipe_add_sub_if
//   Operand/result bus for the pipelined adder/subtractor.
//
//   Handshake: a transfer happens on a rising clk edge where valid && ready.
//   The producer holds its payload stable while valid is high and ready is
//   low; ready may depend combinationally on the downstream ready.
//
//   Signals
//     in_valid, in0, in1, op_sub : operand side, driven by the producer
//     in_ready                   : block can take operands this cycle
//     out_valid, sum, carry, ovf : result side, driven by the block
//     out_ready                  : consumer takes the result this cycle
//
//   Modports
//     master : surrounding logic (drives operands, accepts results)
//     slave  : the pipe_add_sub block itself
// -----------------------------------------------------------------------------
interface pipe_add_sub_if #(
   parameter int WIDTH = 32
) ();

   logic             in_valid;
   logic             in_ready;
   logic [WIDTH-1:0] in0;
   logic [WIDTH-1:0] in1;
   logic             op_sub;
   logic             out_valid;
   logic             out_ready;
   logic [WIDTH-1:0] sum;
   logic             carry;
   logic             ovf;

   modport master (
      output in_valid, in0, in1, op_sub, out_ready,
      input  in_ready, out_valid, sum, carry, ovf
   );

   modport slave (
      input  in_valid, in0, in1, op_sub, out_ready,
      output in_ready, out_valid, sum, carry, ovf
   );

endinterface

// File: rtl/pipe_add_sub.sv
// -----------------------------------------------------------------------------
// pipe_add_sub
//   Pipelined signed adder/subtractor with carry and signed-overflow flags and
//   a valid/ready handshake with backpressure. All arithmetic happens in the
//   first stage; later stages only move {result, carry, ovf, valid} forward.
//   Latency is STAGES cycles without stalls, throughput one result per cycle.
//   Empty stages (bubbles) keep advancing while the output is stalled.
//
//   Parameters
//     WIDTH  : operand/result width (>= 2)
//     STAGES : register stages from acceptance to output (>= 1)
//
//   Ports
//     clk    : clock, rising edge
//     rst_n  : asynchronous active-low reset; drops every in-flight result
//     bus    : pipe_add_sub_if.slave (in_valid/in_ready/in0/in1/op_sub,
//              out_valid/out_ready/sum/carry/ovf)
//
//   Build option
//     PIPE_ADD_SUB_SAT_EN : when defined, an overflowing result saturates to
//                           the most positive / most negative value according
//                           to the sign of in0. carry and ovf are unchanged.
// -----------------------------------------------------------------------------
module pipe_add_sub #(
   parameter int WIDTH  = 32,
   parameter int STAGES = 2
) (
   input  logic           clk,
   input  logic           rst_n,
   pipe_add_sub_if.slave  bus
);

   // ---------------------------------------------------------------------------
   // Stage 1 arithmetic: subtraction is in0 + ~in1 + 1 so one adder serves both.
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0] b_eff;
   logic [WIDTH-1:0] raw;
   logic [WIDTH-1:0] sum_d;
   logic             carry_d;
   logic             ovf_d;

   always_comb begin
      b_eff          = bus.op_sub ? ~bus.in1 : bus.in1;
      {carry_d, raw} = {1'b0, bus.in0} + {1'b0, b_eff} + {{WIDTH{1'b0}}, bus.op_sub};
      // Same-sign operands producing a result of the other sign.
      ovf_d          = (bus.in0[WIDTH-1] == b_eff[WIDTH-1]) &&
                       (raw[WIDTH-1] != bus.in0[WIDTH-1]);
`ifdef PIPE_ADD_SUB_SAT_EN
      if (ovf_d) begin
         sum_d = bus.in0[WIDTH-1] ? {1'b1, {(WIDTH-1){1'b0}}}
                                  : {1'b0, {(WIDTH-1){1'b1}}};
      end else begin
         sum_d = raw;
      end
`else
      sum_d = raw;
`endif
   end

   // ---------------------------------------------------------------------------
   // Pipeline registers, index 1 = first stage, STAGES = output stage.
   // ---------------------------------------------------------------------------
   logic [WIDTH-1:0]  sum_q [1:STAGES];
   logic [STAGES:1]   carry_q;
   logic [STAGES:1]   ovf_q;
   logic [STAGES:1]   v_q;
   logic [STAGES:1]   adv;

   // A stage may load when it is empty or when its contents move on. The chain
   // is evaluated from the output backwards, so bubbles collapse under a stall.
   always_comb begin
      logic chain;
      chain = bus.out_ready;
      adv   = '0;
      for (int k = STAGES; k >= 1; k--) begin
         chain  = !v_q[k] || chain;
         adv[k] = chain;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         v_q     <= '0;
         carry_q <= '0;
         ovf_q   <= '0;
         for (int k = 1; k <= STAGES; k++) begin
            sum_q[k] <= '0;
         end
      end else begin
         if (adv[1]) begin
            v_q[1] <= bus.in_valid;
            // Payload only changes on a real transfer so idle outputs hold.
            if (bus.in_valid) begin
               sum_q[1]   <= sum_d;
               carry_q[1] <= carry_d;
               ovf_q[1]   <= ovf_d;
            end
         end
         for (int k = 2; k <= STAGES; k++) begin
            if (adv[k]) begin
               v_q[k] <= v_q[k-1];
               if (v_q[k-1]) begin
                  sum_q[k]   <= sum_q[k-1];
                  carry_q[k] <= carry_q[k-1];
                  ovf_q[k]   <= ovf_q[k-1];
               end
            end
         end
      end
   end

   assign bus.in_ready  = adv[1];
   assign bus.out_valid = v_q[STAGES];
   assign bus.sum       = sum_q[STAGES];
   assign bus.carry     = carry_q[STAGES];
   assign bus.ovf       = ovf_q[STAGES];

endmodule
